// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 16x-tick timed UART transmitter (start, D_BIT data LSB first, stop).
module uart_tx_serializer #(
  parameter int D_BIT = 8,
  parameter int SB_TICK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_tick,
  input  logic             tx_start,
  input  logic [D_BIT-1:0] din,
  output logic             tx,
  output logic             tx_busy,
  output logic             tx_done_tick
);
  localparam int SW = $clog2(SB_TICK > 16 ? SB_TICK : 16);
  localparam int NW = $clog2(D_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t           state;
  logic [SW-1:0]    s_cnt;
  logic [NW-1:0]    n_cnt;
  logic [D_BIT-1:0] shreg;
  logic             tx_reg;
  logic             bit_end;
  assign bit_end      = s_tick && s_cnt == SW'(15);
  assign tx_done_tick = state == STOP && s_tick && s_cnt == SW'(SB_TICK - 1);
  assign tx_busy      = state != IDLE;
  assign tx           = tx_reg;
  // tx follows the state of the previous cycle, so it lags transitions by one clk
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      s_cnt  <= '0;
      n_cnt  <= '0;
      shreg  <= '0;
      tx_reg <= 1'b1;
    end else begin
      tx_reg <= state == START ? 1'b0 : state == DATA ? shreg[0] : 1'b1;
      case (state)
        IDLE:
          if (tx_start) begin
            shreg <= din;
            s_cnt <= '0;
            state <= START;
          end
        START:
          if (bit_end) begin
            s_cnt <= '0;
            n_cnt <= '0;
            state <= DATA;
          end else if (s_tick) s_cnt <= s_cnt + 1'b1;
        DATA:
          if (bit_end) begin
            s_cnt <= '0;
            shreg <= shreg >> 1;
            if (n_cnt == NW'(D_BIT - 1)) state <= STOP;
            else n_cnt <= n_cnt + 1'b1;
          end else if (s_tick) s_cnt <= s_cnt + 1'b1;
        STOP:
          if (tx_done_tick) state <= IDLE;
          else if (s_tick) s_cnt <= s_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed frames with a line-decoding monitor and expected-word scoreboard.
module tb_uart_tx_serializer;
  logic clk = 0;
  logic rst = 0;
  logic s_tick = 0;
  logic tx_start_a = 0, tx_start_b = 0;
  logic [7:0] din_a = 0;
  logic [4:0] din_b = 0;
  logic tx_a, tx_busy_a, tx_done_tick_a;
  logic tx_b, tx_busy_b, tx_done_tick_b;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int done_cnt_a = 0;
  logic [7:0] exp_q[$];

  uart_tx_serializer #(.D_BIT(8), .SB_TICK(16)) dut_a (
    .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start_a), .din(din_a),
    .tx(tx_a), .tx_busy(tx_busy_a), .tx_done_tick(tx_done_tick_a));

  uart_tx_serializer #(.D_BIT(5), .SB_TICK(32)) dut_b (
    .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start_b), .din(din_b),
    .tx(tx_b), .tx_busy(tx_busy_b), .tx_done_tick(tx_done_tick_b));

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // s_tick is high in every cycle k with k % 4 == 0
  initial forever begin
    @(posedge clk);
    #1;
    s_tick = (cyc % 4 == 0);
  end

  initial forever begin
    @(negedge clk);
    if (tx_done_tick_a === 1'b1) done_cnt_a++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mwait(input int n, inout bit ab);
    repeat (n) begin
      @(negedge clk);
      if (rst === 1'b0) ab = 1;
    end
  endtask

  // Monitor: decode frames on tx_a at bit mid-points (64 clk per bit)
  initial begin
    logic prev;
    logic [7:0] w;
    logic [7:0] e;
    bit ab;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && tx_a === 1'b0 && rst === 1'b1) begin
        ab = 0;
        w = '0;
        mwait(32, ab);
        if (!ab) chk("mon_start_bit", tx_a, 0);
        for (int k = 0; k < 8; k++) begin
          mwait(64, ab);
          w[k] = tx_a;
        end
        mwait(64, ab);
        if (!ab) begin
          chk("mon_stop_bit", tx_a, 1);
          if (exp_q.size() == 0) chk("mon_unexpected_frame", {24'd0, w}, 32'hFFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            chk("mon_frame_data", w, e);
          end
        end
      end
      prev = tx_a;
    end
  end

  task automatic start_a(input logic [7:0] d, input bit push, output int acc);
    @(negedge clk);
    while (cyc % 4 != 0) @(negedge clk);
    din_a = d;
    tx_start_a = 1;
    if (push) exp_q.push_back(d);
    @(negedge clk);
    tx_start_a = 0;
    acc = cyc;
    chk("busy_after_accept", tx_busy_a, 1);
  endtask

  task automatic wait_done_a(output int dc);
    dc = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx_done_tick_a === 1'b1) begin
        dc = cyc;
        break;
      end
    end
    chk("done_seen", dc >= 0, 1);
  endtask

  initial begin
    int acc, dc, d0, nd;
    logic [4:0] pat;
    rst = 0;
    tx_start_a = 1;
    tx_start_b = 1;
    din_a = 8'hA5;
    din_b = 5'h1F;
    repeat (3) begin
      @(negedge clk);
      chk("rst_tx", tx_a, 1);
      chk("rst_busy", tx_busy_a, 0);
      chk("rst_done", tx_done_tick_a, 0);
    end
    chk("rst_busy_b", tx_busy_b, 0);
    tx_start_a = 0;
    tx_start_b = 0;
    rst = 1;
    repeat (4) @(negedge clk);
    chk("no_frame_after_rst", tx_busy_a, 0);
    chk("idle_line", tx_a, 1);

    // single frame with done timing
    d0 = done_cnt_a;
    start_a(8'hB3, 1, acc);
    wait_done_a(dc);
    chk("single_done_time", dc - acc, 639);
    chk("single_busy_at_done", tx_busy_a, 1);
    @(negedge clk);
    chk("single_busy_after", tx_busy_a, 0);
    @(negedge clk);
    chk("single_done_count", done_cnt_a - d0, 1);

    // busy rejection: a second start mid-frame is ignored
    repeat (20) @(negedge clk);
    d0 = done_cnt_a;
    start_a(8'h0F, 1, acc);
    repeat (200) @(negedge clk);
    din_a = 8'hFF;
    tx_start_a = 1;
    @(negedge clk);
    tx_start_a = 0;
    chk("reject_busy", tx_busy_a, 1);
    wait_done_a(dc);
    chk("reject_done_time", dc - acc, 639);
    repeat (100) @(negedge clk);
    chk("reject_done_count", done_cnt_a - d0, 1);
    chk("reject_idle", tx_busy_a, 0);

    // back-to-back with tx_start held high
    @(negedge clk);
    while (cyc % 4 != 0) @(negedge clk);
    din_a = 8'h55;
    tx_start_a = 1;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    @(negedge clk);
    chk("b2b_busy1", tx_busy_a, 1);
    din_a = 8'hAA;
    wait_done_a(dc);
    chk("b2b_tx_at_done", tx_a, 1);
    @(negedge clk);
    chk("b2b_busy_gap", tx_busy_a, 0);
    chk("b2b_tx_gap", tx_a, 1);
    @(negedge clk);
    chk("b2b_restart", tx_busy_a, 1);
    chk("b2b_tx_still_high", tx_a, 1);
    @(negedge clk);
    tx_start_a = 0;
    chk("b2b_tx_start_bit", tx_a, 0);
    wait_done_a(dc);
    repeat (20) @(negedge clk);

    // reset during data bit 4 of 8'h00
    d0 = done_cnt_a;
    start_a(8'h00, 0, acc);
    repeat (338) @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1;
    chk("midrst_tx", tx_a, 1);
    chk("midrst_busy", tx_busy_a, 0);
    chk("midrst_done", tx_done_tick_a, 0);
    repeat (700) @(negedge clk);
    chk("midrst_no_done", done_cnt_a - d0, 0);
    start_a(8'h3C, 1, acc);
    wait_done_a(dc);
    chk("midrst_next_done_time", dc - acc, 639);

    // variant D_BIT=5, SB_TICK=32
    pat = 5'b10101;
    @(negedge clk);
    while (cyc % 4 != 0) @(negedge clk);
    din_b = pat;
    tx_start_b = 1;
    @(negedge clk);
    tx_start_b = 0;
    chk("b_busy", tx_busy_b, 1);
    nd = 0;
    for (int t = 1; t <= 520; t++) begin
      @(negedge clk);
      if (t == 33) chk("b_start_bit", tx_b, 0);
      else if (t >= 97 && t <= 353 && (t - 33) % 64 == 0) chk("b_data_bit", tx_b, pat[(t - 33) / 64 - 1]);
      else if (t == 417 || t == 481) chk("b_stop_bit", tx_b, 1);
      if (tx_done_tick_b === 1'b1) begin
        nd++;
        chk("b_done_time", t, 511);
      end
    end
    chk("b_done_count", nd, 1);
    chk("b_idle", tx_busy_b, 0);

    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Parallel-to-serial UART transmitter. Accepts one D_BIT-wide word per start request, emits it on the serial line as start bit, D_BIT data bits LSB first, and stop bit(s), all timed by an external 16x oversampling tick. It is the transmit-side counterpart to the receive/register path. It sits between the transmit register (source of `din` and the start strobe) and the serial output pin.

## Interface
Parameters:
- D_BIT, 8: data bits per frame (5..9 legal)
- SB_TICK, 16: s_tick count for the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2)

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- rst  input  1  synchronous, active-low reset; sampled on rising edge of clk
- s_tick  input  1  one-clk-wide oversampling strobe, 16 per bit period
- tx_start  input  1  request to transmit `din`; sampled only in IDLE
- din  input  D_BIT  word to transmit
- tx  output  1  serial line, registered, idle-high
- tx_busy  output  1  high while a frame is in progress (state != IDLE)
- tx_done_tick  output  1  one-clk pulse at end of stop period

## Operation
- FSM states: IDLE, START, DATA, STOP. Registers: state, s_cnt (tick counter, width fits max(15, SB_TICK-1)), n_cnt (bit index, clog2(D_BIT) bits), shreg (D_BIT bits), tx_reg.
- IDLE: tx = 1. When tx_start = 1: shreg <= din, s_cnt <= 0, state <= START. s_tick ignored.
- START: tx = 0. On s_tick: if s_cnt == 15 then s_cnt <= 0, n_cnt <= 0, state <= DATA; else s_cnt++.
- DATA: tx = shreg[0]. On s_tick: if s_cnt == 15 then s_cnt <= 0, shreg >>= 1, and either n_cnt == D_BIT-1 -> STOP, or n_cnt++; else s_cnt++.
- STOP: tx = 1. On s_tick: if s_cnt == SB_TICK-1 then tx_done_tick = 1 for that cycle and state <= IDLE; else s_cnt++.
- Cycles without s_tick hold all counters and the shift register.
- tx_start while busy is ignored. `din` is not sampled after acceptance, so changes mid-frame have no effect.
- Frame length = 16*(1+D_BIT) + SB_TICK s_ticks (160 for defaults).

## Timing
- Reset (rst = 0 at an edge): state = IDLE, s_cnt = 0, n_cnt = 0, shreg = 0, tx = 1, tx_busy = 0, tx_done_tick = 0 after that edge. Reset overrides every other input, including mid-frame; the line returns high on the next edge and no done pulse is produced.
- tx is registered: it reflects the new state one clk after the state transition edge. Acceptance edge N gives state = START and tx_busy = 1 after N; tx = 0 after edge N+1.
- tx_done_tick is combinational from the STOP state and the final s_tick, high in the same cycle as that s_tick; state is IDLE after the next edge. tx_busy falls at that same edge.
- Back-to-back: a tx_start coincident with tx_done_tick is ignored because the state is still STOP. The earliest acceptance is the following cycle. The source must hold or re-assert tx_start.
- s_tick and tx_start in the same IDLE cycle: the start is accepted and the tick does not count toward START.

## Test plan
- Reset: hold rst = 0 for 3 clk with tx_start = 1 -> tx = 1, tx_busy = 0, tx_done_tick = 0 throughout; no frame starts.
- Single frame: din = 8'hB3, one-cycle tx_start, s_tick every 4 clk -> bits sampled at tick mid-points are 0,1,1,0,0,1,1,0,1,1; exactly one tx_done_tick 640 clk after acceptance (±1); tx_busy high across the frame.
- Busy rejection: start 8'h0F, then pulse tx_start with din = 8'hFF in DATA -> line carries only 8'h0F; exactly one done pulse.
- Back-to-back: tx_start held high continuously with din = 8'h55 then 8'hAA -> done pulse, then a new START exactly 2 clk later (tx low one clk after that). No glitch high-to-low inside the stop bit.
- Reset mid-frame: assert rst = 0 during DATA bit 4 of 8'h00 -> tx = 1 after next edge, no done pulse; the next tx_start yields a complete correct frame.
- Parameter variant: D_BIT = 5, SB_TICK = 32, din = 5'b10101 -> 5 data bits 1,0,1,0,1; stop high for 32 ticks; frame = 128 ticks.
